// File: rtl/R5FP_arb_pkg.sv
// rtl/R5FP_arb_pkg.sv - shared types and constants for the divide/sqrt engine arbiter
package R5FP_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam logic OWN_DIV  = 1'b0;
    localparam logic OWN_SQRT = 1'b1;

endpackage

// File: rtl/R5FP_rr_arb2.sv
// rtl/R5FP_rr_arb2.sv - two-input round-robin picker (divide vs sqrt) with priority register
module R5FP_rr_arb2
    import R5FP_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_div,
    input  logic req_sqrt,
    input  logic upd_en,
    input  logic served,
    output logic pick_valid,
    output logic pick_sqrt
);

    // prio = 0 lets divide win a tie, 1 lets sqrt win; the requester just served loses the next tie
    logic prio;

    // priority register flips away from whoever was just served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (upd_en) begin
            prio <= (served == OWN_DIV) ? 1'b1 : 1'b0;
        end
    end

    // a lone requester always wins; ties resolved by prio
    always_comb begin
        pick_valid = req_div | req_sqrt;
        pick_sqrt  = req_sqrt & (~req_div | prio);
    end

endmodule

// File: rtl/r5fp_div_sqrt_arb.sv
// rtl/r5fp_div_sqrt_arb.sv - shares one divide/sqrt engine between two requesters (option macro R5FP_DIVSQRT_ARB_OUTREG_EN)
module r5fp_div_sqrt_arb
    import R5FP_arb_pkg::*;
#(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         div_req_i,
    input  logic [W-1:0] div_N_i,
    input  logic [W-1:0] div_D_i,
    output logic         div_ack_o,
    output logic         div_done_o,
    input  logic         sqrt_req_i,
    input  logic [W-1:0] sqrt_D_i,
    output logic         sqrt_ack_o,
    output logic         sqrt_done_o,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] eng_N_o,
    output logic [W-1:0] eng_D_o,
    output logic         eng_strobe_o,
    output logic         eng_is_div_o,
    input  logic [W-1:0] eng_Quo_i,
    input  logic [W-1:0] eng_Rem_i,
    input  logic         eng_done_i,
    input  logic         eng_ready_i,
    output logic         busy_o,
    output logic         owner_o,
    output logic         err_o
);

    arb_state_t   state;
    arb_state_t   next_state;
    logic [W-1:0] n_q;
    logic [W-1:0] d_q;
    logic         is_div_q;
    logic         owner_q;
    logic         err_q;
    logic         pick_valid;
    logic         pick_sqrt;
    logic         grant;
    logic         done_now;

    R5FP_rr_arb2 u_rr_arb (
        .clk        (clk),
        .reset      (reset),
        .req_div    (div_req_i),
        .req_sqrt   (sqrt_req_i),
        .upd_en     (done_now),
        .served     (owner_q),
        .pick_valid (pick_valid),
        .pick_sqrt  (pick_sqrt)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next state: grant -> wait for engine ready -> wait for engine done
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid)  next_state = ISSUE;
            ISSUE:   if (eng_ready_i) next_state = BUSY;
            BUSY:    if (eng_done_i)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Mealy outputs: ack in IDLE, strobe in ISSUE, completion in BUSY
    always_comb begin
        grant        = 1'b0;
        done_now     = 1'b0;
        div_ack_o    = 1'b0;
        sqrt_ack_o   = 1'b0;
        eng_strobe_o = 1'b0;
        case (state)
            IDLE: begin
                grant      = pick_valid;
                div_ack_o  = pick_valid & ~pick_sqrt;
                sqrt_ack_o = pick_valid & pick_sqrt;
            end
            ISSUE:   eng_strobe_o = eng_ready_i;
            BUSY:    done_now     = eng_done_i;
            default: ;
        endcase
    end

    // capture the winner's operands and ownership on the grant edge; sqrt has no dividend
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q      <= '0;
            d_q      <= '0;
            is_div_q <= 1'b0;
            owner_q  <= OWN_DIV;
        end else if (grant) begin
            owner_q  <= pick_sqrt ? OWN_SQRT : OWN_DIV;
            is_div_q <= ~pick_sqrt;
            n_q      <= pick_sqrt ? '0 : div_N_i;
            d_q      <= pick_sqrt ? sqrt_D_i : div_D_i;
        end
    end

    // sticky flag for an engine completion nobody was waiting for
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (eng_done_i && (state != BUSY)) begin
            err_q <= 1'b1;
        end
    end

`ifdef R5FP_DIVSQRT_ARB_OUTREG_EN
    // registered response; the FSM has already moved on, so this may overlap the next grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_o       <= '0;
            rem_o       <= '0;
            div_done_o  <= 1'b0;
            sqrt_done_o <= 1'b0;
        end else begin
            div_done_o  <= done_now & (owner_q == OWN_DIV);
            sqrt_done_o <= done_now & (owner_q == OWN_SQRT);
            if (done_now) begin
                quo_o <= eng_Quo_i;
                rem_o <= eng_Rem_i;
            end
        end
    end
`else
    // combinational response in the engine's done cycle; result bus held at zero otherwise
    always_comb begin
        div_done_o  = done_now & (owner_q == OWN_DIV);
        sqrt_done_o = done_now & (owner_q == OWN_SQRT);
        quo_o       = done_now ? eng_Quo_i : '0;
        rem_o       = done_now ? eng_Rem_i : '0;
    end
`endif

    assign eng_N_o      = n_q;
    assign eng_D_o      = d_q;
    assign eng_is_div_o = is_div_q;
    assign owner_o      = owner_q;
    assign busy_o       = (state != IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_r5fp_div_sqrt_arb.sv
// tb/tb_r5fp_div_sqrt_arb.sv - self-checking bench: engine model, result/arbitration model, directed vectors
module tb_r5fp_div_sqrt_arb;

    localparam int W   = 26;
    localparam int LAT = 4;
`ifdef R5FP_DIVSQRT_ARB_OUTREG_EN
    localparam int RSP = 1;
`else
    localparam int RSP = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         div_req_i = 1'b0;
    logic [W-1:0] div_N_i = '0;
    logic [W-1:0] div_D_i = '0;
    logic         div_ack_o, div_done_o;
    logic         sqrt_req_i = 1'b0;
    logic [W-1:0] sqrt_D_i = '0;
    logic         sqrt_ack_o, sqrt_done_o;
    logic [W-1:0] quo_o, rem_o, eng_N_o, eng_D_o;
    logic         eng_strobe_o, eng_is_div_o;
    logic [W-1:0] eng_Quo_i, eng_Rem_i;
    logic         eng_done_i, eng_ready_i;
    logic         busy_o, owner_o, err_o;

    logic         ready_en = 1'b1;
    logic         spur = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    r5fp_div_sqrt_arb #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .div_req_i(div_req_i), .div_N_i(div_N_i), .div_D_i(div_D_i),
        .div_ack_o(div_ack_o), .div_done_o(div_done_o),
        .sqrt_req_i(sqrt_req_i), .sqrt_D_i(sqrt_D_i),
        .sqrt_ack_o(sqrt_ack_o), .sqrt_done_o(sqrt_done_o),
        .quo_o(quo_o), .rem_o(rem_o),
        .eng_N_o(eng_N_o), .eng_D_o(eng_D_o),
        .eng_strobe_o(eng_strobe_o), .eng_is_div_o(eng_is_div_o),
        .eng_Quo_i(eng_Quo_i), .eng_Rem_i(eng_Rem_i),
        .eng_done_i(eng_done_i), .eng_ready_i(eng_ready_i),
        .busy_o(busy_o), .owner_o(owner_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint isqrt(input longint x);
        longint q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        return q;
    endfunction

    // engine stand-in: fixed latency, done pulse LAT+1 cycles after the strobe cycle
    logic         e_busy, e_done, e_isdiv;
    int           e_cnt;
    logic [W-1:0] e_n, e_d, e_q, e_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_busy <= 1'b0; e_done <= 1'b0; e_isdiv <= 1'b0; e_cnt <= 0;
            e_n <= '0; e_d <= '0; e_q <= '0; e_r <= '0;
        end else begin
            e_done <= 1'b0;
            if (e_busy) begin
                if (e_cnt == 1) begin
                    e_done <= 1'b1;
                    e_busy <= 1'b0;
                    if (e_isdiv) begin
                        e_q <= e_n / e_d;
                        e_r <= e_n % e_d;
                    end else begin
                        e_q <= W'(isqrt(longint'(e_d)));
                        e_r <= W'(longint'(e_d) - isqrt(longint'(e_d)) * isqrt(longint'(e_d)));
                    end
                end
                e_cnt <= e_cnt - 1;
            end else if (eng_strobe_o) begin
                e_busy  <= 1'b1;
                e_cnt   <= LAT;
                e_n     <= eng_N_o;
                e_d     <= eng_D_o;
                e_isdiv <= eng_is_div_o;
            end
        end
    end
    assign eng_ready_i = ready_en & ~e_busy;
    assign eng_done_i  = e_done | spur;
    assign eng_Quo_i   = e_q;
    assign eng_Rem_i   = e_r;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // model state: who owns the engine, whether it was started, expected result
    bit      m_owned, m_started, m_prio, m_err, m_owner;
    longint  m_n, m_d, m_q, m_r;
    bit      p_pend, p_owner;
    longint  p_q, p_r;
    int      div_done_cnt = 0, sqrt_done_cnt = 0;
    int      last_strobe_cyc = -1, last_div_done_cyc = -1;

    task automatic compare_loop();
        bit     exp_strobe, fin, fire, f_owner, wd, ws;
        longint f_q, f_r;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_owned = 0; m_started = 0; m_prio = 0; m_err = 0; m_owner = 0;
                p_pend = 0;
                continue;
            end
            if (div_done_o)   begin div_done_cnt++;  last_div_done_cyc = cyc; end
            if (sqrt_done_o)  sqrt_done_cnt++;
            if (eng_strobe_o) last_strobe_cyc = cyc;

            chk("busy", busy_o, m_owned);
            chk("err", err_o, m_err);
            if (m_owned) begin
                chk("owner", owner_o, m_owner);
                chk("eng_N", eng_N_o, m_n);
                chk("eng_D", eng_D_o, m_d);
                chk("eng_is_div", eng_is_div_o, !m_owner);
            end
            exp_strobe = m_owned && !m_started && eng_ready_i;
            chk("strobe", eng_strobe_o, exp_strobe);

            fin = m_started && eng_done_i;
            if (RSP == 1) begin
                fire = p_pend; f_owner = p_owner; f_q = p_q; f_r = p_r;
                p_pend = fin; p_owner = m_owner; p_q = m_q; p_r = m_r;
            end else begin
                fire = fin; f_owner = m_owner; f_q = m_q; f_r = m_r;
            end
            chk("div_done", div_done_o, fire && !f_owner);
            chk("sqrt_done", sqrt_done_o, fire && f_owner);
            if (fire) begin
                chk("quo", quo_o, f_q);
                chk("rem", rem_o, f_r);
            end
            if (eng_done_i && !m_started) m_err = 1;

            wd = !m_owned && div_req_i && (!sqrt_req_i || !m_prio);
            ws = !m_owned && sqrt_req_i && (!div_req_i || m_prio);
            chk("div_ack", div_ack_o, wd);
            chk("sqrt_ack", sqrt_ack_o, ws);
            if (wd) begin
                m_owned = 1; m_started = 0; m_owner = 0;
                m_n = div_N_i; m_d = div_D_i; m_q = m_n / m_d; m_r = m_n % m_d;
            end else if (ws) begin
                m_owned = 1; m_started = 0; m_owner = 1;
                m_n = 0; m_d = sqrt_D_i; m_q = isqrt(m_d); m_r = m_d - m_q * m_q;
            end
            if (exp_strobe) m_started = 1;
            if (fin) begin
                m_owned = 0; m_started = 0; m_prio = !m_owner;
            end
        end
    endtask

    task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] d, output int ack_cyc);
        div_N_i = n; div_D_i = d; div_req_i = 1'b1; ack_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (div_ack_o) begin ack_cyc = cyc; break; end
        end
        if (ack_cyc < 0) timeout_fail("div_ack_wait");
        @(posedge clk); #1;
        div_req_i = 1'b0;
    endtask

    task automatic do_sqrt(input logic [W-1:0] d, output int ack_cyc);
        sqrt_D_i = d; sqrt_req_i = 1'b1; ack_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sqrt_ack_o) begin ack_cyc = cyc; break; end
        end
        if (ack_cyc < 0) timeout_fail("sqrt_ack_wait");
        @(posedge clk); #1;
        sqrt_req_i = 1'b0;
    endtask

    task automatic wait_done(input bit is_sqrt, output int c, output longint q, output longint r);
        c = -1; q = -1; r = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (is_sqrt ? sqrt_done_o : div_done_o) begin
                c = cyc; q = quo_o; r = rem_o; break;
            end
        end
        if (c < 0) timeout_fail(is_sqrt ? "sqrt_done_wait" : "div_done_wait");
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst_ctl", {div_ack_o, div_done_o, sqrt_ack_o, sqrt_done_o, eng_strobe_o,
                        eng_is_div_o, busy_o, owner_o, err_o}, 0);
        chk("rst_quo_rem", {quo_o, rem_o}, 0);
        chk("rst_eng_ops", {eng_N_o, eng_D_o}, 0);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int a, a2, c, dcnt, scnt;
        longint q, r;
        fork compare_loop(); join_none
        repeat (2) @(posedge clk);
        do_reset();

        // lone divide
        @(posedge clk); #1;
        scnt = sqrt_done_cnt;
        do_div(100, 7, a);
        wait_done(0, c, q, r);
        chk("t1_quo", q, 14);
        chk("t1_rem", r, 2);
        chk("t1_strobe_cyc", last_strobe_cyc, a + 1);
        chk("t1_done_cyc", c, a + LAT + 2 + RSP);
        chk("t1_no_sqrt_done", sqrt_done_cnt, scnt);

        // simultaneous requests from reset: divide first, sqrt right after
        do_reset();
        @(posedge clk); #1;
        fork
            do_div(100, 7, a);
            do_sqrt(144, a2);
        join
        wait_done(1, c, q, r);
        chk("t2_div_first", a2 > a, 1);
        chk("t2_sqrt_ack_cyc", a2, last_div_done_cyc + 1 - RSP);
        chk("t2_quo", q, 12);
        chk("t2_rem", r, 0);

        // lone divide leaves prio on sqrt, so the next tie serves sqrt first
        @(posedge clk); #1;
        do_div(100, 7, a);
        wait_done(0, c, q, r);
        @(posedge clk); #1;
        fork
            do_div(50, 5, a);
            do_sqrt(81, a2);
        join
        chk("t3_sqrt_first", a2 < a, 1);
        wait_done(0, c, q, r);
        chk("t3_quo", q, 10);
        chk("t3_rem", r, 0);

        // engine not ready for three ISSUE cycles
        @(posedge clk); #1;
        ready_en = 1'b0;
        do_div(200, 9, a);
        repeat (3) @(posedge clk);
        #1 ready_en = 1'b1;
        wait_done(0, c, q, r);
        chk("t4_strobe_cyc", last_strobe_cyc, a + 4);
        chk("t4_quo", q, 22);
        chk("t4_rem", r, 2);

        // spurious engine done while idle
        dcnt = div_done_cnt; scnt = sqrt_done_cnt;
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_set", err_o, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_err_sticky", err_o, 1);
        chk("t5_no_done", div_done_cnt + sqrt_done_cnt, dcnt + scnt);

        // reset in the middle of a divide, then a fresh sqrt
        @(posedge clk); #1;
        do_div(1000, 3, a);
        repeat (2) @(posedge clk);
        do_reset();
        dcnt = div_done_cnt;
        @(posedge clk); #1;
        do_sqrt(16, a2);
        wait_done(1, c, q, r);
        chk("t6_quo", q, 4);
        chk("t6_rem", r, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_stale_div_done", div_done_cnt, dcnt);
        chk("t6_err_cleared", err_o, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
